// File: rtl/acc_cpu_pkg.sv
// Shared definitions for the 8-bit accumulator CPU control path.
// Holds the opcode map, ALU operation encodings, controller state encoding,
// instruction field positions and small decode helpers.
package acc_cpu_pkg;

  // Instruction fields: IR[7:4] = opcode, IR[3:0] = operand address.
  localparam int IR_OPC_MSB  = 7;
  localparam int IR_OPC_LSB  = 4;
  localparam int IR_ADDR_MSB = 3;
  localparam int IR_ADDR_LSB = 0;

  // Opcodes. 4'hB..4'hE are undefined.
  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_STA = 4'h2;
  localparam logic [3:0] OP_ADD = 4'h3;
  localparam logic [3:0] OP_SUB = 4'h4;
  localparam logic [3:0] OP_AND = 4'h5;
  localparam logic [3:0] OP_OR  = 4'h6;
  localparam logic [3:0] OP_NOT = 4'h7;
  localparam logic [3:0] OP_JMP = 4'h8;
  localparam logic [3:0] OP_JZ  = 4'h9;
  localparam logic [3:0] OP_JN  = 4'hA;
  localparam logic [3:0] OP_HLT = 4'hF;

  // ALU operation select.
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_NOT = 3'b100;

  // Controller states.
  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_MEM_RD = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM_WR = 3'd4,
    ST_HALT   = 3'd5
  } ctrl_state_e;

  // ALU select for the opcode being executed; non-ALU opcodes map to ADD,
  // which is harmless because ACC is then loaded from memory or not at all.
  function automatic logic [2:0] alu_op_for(input logic [3:0] op);
    logic [2:0] sel;
    case (op)
      OP_ADD:  sel = ALU_ADD;
      OP_SUB:  sel = ALU_SUB;
      OP_AND:  sel = ALU_AND;
      OP_OR:   sel = ALU_OR;
      OP_NOT:  sel = ALU_NOT;
      default: sel = ALU_ADD;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/acc_cpu_wait_timer.sv
// Memory wait timer.
// Counts cycles spent waiting on a memory handshake and flags when the count
// has reached LIMIT. The count saturates at LIMIT.
//   clk     : clock, rising edge
//   reset   : synchronous active-high reset, clears the count
//   clr     : synchronous clear (takes priority over en)
//   en      : advance the count by one
//   expired : count equals LIMIT
module acc_cpu_wait_timer #(
  parameter int LIMIT = 15,
  parameter int CW    = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [CW-1:0] LIMIT_C = CW'(LIMIT);
  localparam logic [CW-1:0] ONE_C   = {{(CW-1){1'b0}}, 1'b1};

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  // Next count: clear, increment (saturating at LIMIT) or hold.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = {CW{1'b0}};
    end else if (en && (count_q != LIMIT_C)) begin
      count_d = count_q + ONE_C;
    end else begin
      count_d = count_q;
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= {CW{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = (count_q == LIMIT_C);

endmodule

// File: rtl/acc_cpu_ctrl.sv
// Multi-cycle control FSM for the 8-bit accumulator CPU.
// Sequences FETCH / DECODE / MEM_RD / EXEC / MEM_WR / HALT and drives the
// datapath strobes. Data memory accesses use a ready handshake guarded by a
// wait timer; a timeout latches bus_error and parks the controller in HALT.
//   clock, reset            : clock and synchronous active-high reset
//   opcode                  : IR[7:4], valid from DECODE onward
//   acc_zero, acc_neg       : ACC status for conditional jumps
//   mem_ready               : data memory completed current access
//   ld_ir, ld_pc, pc_src    : IR/PC load controls (pc_src 1 = IR operand)
//   jmp_uncond              : unconditional jump taken
//   ld_ac, ac_src, alu_op   : ACC load control, source select, ALU op
//   mReadFlag, mWriteFlag   : data memory requests
//   halted, bus_error       : HALT state, sticky timeout flag
//   illegal_op              : one-cycle pulse on an undefined opcode
module acc_cpu_ctrl
  import acc_cpu_pkg::*;
#(
  parameter int WAIT_LIMIT = 15,
  parameter int CW         = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] opcode,
  input  logic       acc_zero,
  input  logic       acc_neg,
  input  logic       mem_ready,
  output logic       ld_ir,
  output logic       ld_pc,
  output logic       pc_src,
  output logic       jmp_uncond,
  output logic       ld_ac,
  output logic       ac_src,
  output logic [2:0] alu_op,
  output logic       mReadFlag,
  output logic       mWriteFlag,
  output logic       halted,
  output logic       bus_error,
  output logic       illegal_op
);

  ctrl_state_e state_q;
  ctrl_state_e state_d;
  logic        bus_error_q;
  logic        bus_error_d;

  logic        timer_clr_s;
  logic        timer_en_s;
  logic        timer_expired_s;

  logic        ld_ir_s;
  logic        ld_pc_s;
  logic        pc_src_s;
  logic        jmp_uncond_s;
  logic        ld_ac_s;
  logic        ac_src_s;
  logic [2:0]  alu_op_s;
  logic        mem_rd_s;
  logic        mem_wr_s;
  logic        halted_s;
  logic        illegal_op_s;

  // The timer is held clear outside the memory states, so every entry into
  // MEM_RD / MEM_WR starts from zero.
  acc_cpu_wait_timer #(
    .LIMIT (WAIT_LIMIT),
    .CW    (CW)
  ) u_wait_timer (
    .clk     (clock),
    .reset   (reset),
    .clr     (timer_clr_s),
    .en      (timer_en_s),
    .expired (timer_expired_s)
  );

  // Next-state and strobe decode from the current state and inputs.
  always_comb begin
    state_d      = state_q;
    bus_error_d  = bus_error_q;
    timer_clr_s  = 1'b1;
    timer_en_s   = 1'b0;
    ld_ir_s      = 1'b0;
    ld_pc_s      = 1'b0;
    pc_src_s     = 1'b0;
    jmp_uncond_s = 1'b0;
    ld_ac_s      = 1'b0;
    ac_src_s     = 1'b0;
    alu_op_s     = ALU_ADD;
    mem_rd_s     = 1'b0;
    mem_wr_s     = 1'b0;
    halted_s     = 1'b0;
    illegal_op_s = 1'b0;

    case (state_q)
      ST_FETCH: begin
        ld_ir_s = 1'b1;
        state_d = ST_DECODE;
      end

      ST_DECODE: begin
        case (opcode)
          OP_LDA, OP_ADD, OP_SUB, OP_AND, OP_OR: state_d = ST_MEM_RD;
          OP_STA: state_d = ST_MEM_WR;
          OP_NOT: state_d = ST_EXEC;
          OP_NOP: begin
            ld_pc_s = 1'b1;
            state_d = ST_FETCH;
          end
          OP_JMP: begin
            ld_pc_s      = 1'b1;
            pc_src_s     = 1'b1;
            jmp_uncond_s = 1'b1;
            state_d      = ST_FETCH;
          end
          OP_JZ: begin
            ld_pc_s  = 1'b1;
            pc_src_s = acc_zero;
            state_d  = ST_FETCH;
          end
          OP_JN: begin
            ld_pc_s  = 1'b1;
            pc_src_s = acc_neg;
            state_d  = ST_FETCH;
          end
          OP_HLT: state_d = ST_HALT;
          default: begin
            // Undefined opcode: flag it and skip like a NOP.
            illegal_op_s = 1'b1;
            ld_pc_s      = 1'b1;
            state_d      = ST_FETCH;
          end
        endcase
      end

      ST_MEM_RD: begin
        mem_rd_s    = 1'b1;
        timer_clr_s = 1'b0;
        // A ready arriving on the last allowed cycle still wins.
        if (mem_ready) begin
          state_d = ST_EXEC;
        end else if (timer_expired_s) begin
          bus_error_d = 1'b1;
          state_d     = ST_HALT;
        end else begin
          timer_en_s = 1'b1;
        end
      end

      ST_EXEC: begin
        ld_ac_s  = 1'b1;
        ld_pc_s  = 1'b1;
        ac_src_s = (opcode == OP_LDA);
        alu_op_s = alu_op_for(opcode);
        state_d  = ST_FETCH;
      end

      ST_MEM_WR: begin
        mem_wr_s    = 1'b1;
        timer_clr_s = 1'b0;
        if (mem_ready) begin
          ld_pc_s = 1'b1;
          state_d = ST_FETCH;
        end else if (timer_expired_s) begin
          bus_error_d = 1'b1;
          state_d     = ST_HALT;
        end else begin
          timer_en_s = 1'b1;
        end
      end

      ST_HALT: begin
        halted_s = 1'b1;
        state_d  = ST_HALT;
      end

      default: begin
        state_d = ST_FETCH;
      end
    endcase
  end

  // State and sticky error registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_FETCH;
      bus_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bus_error_q <= bus_error_d;
    end
  end

  // Force every output low while reset is high; this also drops memory
  // requests immediately when an access is aborted by reset.
  always_comb begin
    if (reset) begin
      ld_ir      = 1'b0;
      ld_pc      = 1'b0;
      pc_src     = 1'b0;
      jmp_uncond = 1'b0;
      ld_ac      = 1'b0;
      ac_src     = 1'b0;
      alu_op     = 3'b000;
      mReadFlag  = 1'b0;
      mWriteFlag = 1'b0;
      halted     = 1'b0;
      bus_error  = 1'b0;
      illegal_op = 1'b0;
    end else begin
      ld_ir      = ld_ir_s;
      ld_pc      = ld_pc_s;
      pc_src     = pc_src_s;
      jmp_uncond = jmp_uncond_s;
      ld_ac      = ld_ac_s;
      ac_src     = ac_src_s;
      alu_op     = alu_op_s;
      mReadFlag  = mem_rd_s;
      mWriteFlag = mem_wr_s;
      halted     = halted_s;
      bus_error  = bus_error_q;
      illegal_op = illegal_op_s;
    end
  end

endmodule

// File: tb/tb_acc_cpu_ctrl.sv
// Testbench for acc_cpu_ctrl: an instruction-level reference model expands
// each instruction into its expected per-cycle strobe trace.
module tb_acc_cpu_ctrl;

  localparam int WAIT_LIMIT = 15;
  localparam int CW         = 4;

  // Outcome codes returned by run_instr.
  localparam int RES_OK      = 0;
  localparam int RES_HALT    = 1;
  localparam int RES_TIMEOUT = 2;
  localparam int RES_ABORT   = 3;

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] opcode;
  logic       acc_zero;
  logic       acc_neg;
  logic       mem_ready;
  logic       ld_ir, ld_pc, pc_src, jmp_uncond, ld_ac, ac_src;
  logic [2:0] alu_op;
  logic       mReadFlag, mWriteFlag, halted, bus_error, illegal_op;

  int checks   = 0;
  int failures = 0;

  logic [13:0] obs_s;
  assign obs_s = {ld_ir, ld_pc, pc_src, jmp_uncond, ld_ac, ac_src, alu_op,
                  mReadFlag, mWriteFlag, halted, bus_error, illegal_op};

  acc_cpu_ctrl #(
    .WAIT_LIMIT (WAIT_LIMIT),
    .CW         (CW)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .opcode     (opcode),
    .acc_zero   (acc_zero),
    .acc_neg    (acc_neg),
    .mem_ready  (mem_ready),
    .ld_ir      (ld_ir),
    .ld_pc      (ld_pc),
    .pc_src     (pc_src),
    .jmp_uncond (jmp_uncond),
    .ld_ac      (ld_ac),
    .ac_src     (ac_src),
    .alu_op     (alu_op),
    .mReadFlag  (mReadFlag),
    .mWriteFlag (mWriteFlag),
    .halted     (halted),
    .bus_error  (bus_error),
    .illegal_op (illegal_op)
  );

  always #5 clock = ~clock;

  // Expected output vector in obs_s bit order.
  function automatic logic [13:0] ev(input bit ir, input bit pc, input bit src,
                                     input bit jmp, input bit ac, input bit acs,
                                     input logic [2:0] alu, input bit rd,
                                     input bit wr, input bit h, input bit be,
                                     input bit ill);
    return {ir, pc, src, jmp, ac, acs, alu, rd, wr, h, be, ill};
  endfunction

  function automatic logic [2:0] alu_ref(input logic [3:0] op);
    case (op)
      4'd4:    return 3'b001;
      4'd5:    return 3'b010;
      4'd6:    return 3'b011;
      4'd7:    return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  task automatic chk_val(input string tag, input logic [13:0] obs, input logic [13:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%b expected=%b (ir pc src jmp ac acs alu[3] rd wr h be ill) t=%0t",
               tag, obs, exp, $time);
    end
  endtask

  // One clock cycle: inputs already driven; compare at the falling edge.
  task automatic cyc(input string tag, input logic [13:0] exp);
    @(negedge clock);
    chk_val(tag, obs_s, exp);
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    for (int i = 0; i < n; i++) begin
      opcode    = 4'($urandom);
      mem_ready = 1'($urandom);
      acc_zero  = 1'($urandom);
      acc_neg   = 1'($urandom);
      cyc("reset_outputs_zero", 14'd0);
    end
    reset = 1'b0;
  endtask

  task automatic chk_halt(input bit be, input int n);
    for (int i = 0; i < n; i++) begin
      mem_ready = 1'($urandom);
      opcode    = 4'($urandom);
      cyc("halt_hold", ev(0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 1, be, 0));
    end
  endtask

  // Run one instruction from FETCH. w = wait cycles before mem_ready
  // (w > WAIT_LIMIT never delivers ready). abort_at >= 0 raises reset in
  // that memory cycle.
  task automatic run_instr(input logic [3:0] op, input int w, input bit z,
                           input bit n, input int abort_at, output int res);
    bit is_rd, is_wr, ill;
    logic [13:0] dec;
    res   = RES_OK;
    is_rd = (op == 4'd1) || (op >= 4'd3 && op <= 4'd6);
    is_wr = (op == 4'd2);
    ill   = (op >= 4'd11 && op <= 4'd14);

    // FETCH ignores opcode and status inputs.
    opcode    = 4'($urandom);
    mem_ready = 1'($urandom);
    acc_zero  = 1'($urandom);
    acc_neg   = 1'($urandom);
    cyc("fetch", ev(1, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0));

    opcode    = op;
    acc_zero  = z;
    acc_neg   = n;
    mem_ready = 1'($urandom);
    if (op == 4'd0 || ill)  dec = ev(0, 1, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, ill);
    else if (op == 4'd8)    dec = ev(0, 1, 1, 1, 0, 0, 3'b000, 0, 0, 0, 0, 0);
    else if (op == 4'd9)    dec = ev(0, 1, z, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0);
    else if (op == 4'd10)   dec = ev(0, 1, n, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0);
    else                    dec = 14'd0;
    cyc("decode", dec);
    acc_zero = 1'($urandom);
    acc_neg  = 1'($urandom);

    if (is_rd || is_wr) begin
      for (int k = 0; k <= WAIT_LIMIT; k++) begin
        mem_ready = (k == w);
        if (k == abort_at) begin
          reset = 1'b1;
          cyc("abort_outputs_zero", 14'd0);
          res = RES_ABORT;
          return;
        end
        if (is_rd) cyc("mem_rd", ev(0, 0, 0, 0, 0, 0, 3'b000, 1, 0, 0, 0, 0));
        else       cyc("mem_wr", ev(0, (k == w), 0, 0, 0, 0, 3'b000, 0, 1, 0, 0, 0));
        if (k == w) break;
      end
      if (w > WAIT_LIMIT) begin
        res = RES_TIMEOUT;
        return;
      end
    end

    if (is_rd || op == 4'd7) begin
      mem_ready = 1'($urandom);
      cyc("exec", ev(0, 1, 0, 0, 1, (op == 4'd1), alu_ref(op), 0, 0, 0, 0, 0));
    end

    if (op == 4'd15) res = RES_HALT;
  endtask

  task automatic after(input int res);
    if (res == RES_HALT) begin
      chk_halt(1'b0, 3);
      do_reset(2);
    end else if (res == RES_TIMEOUT) begin
      chk_halt(1'b1, 3);
      do_reset(2);
    end else if (res == RES_ABORT) begin
      do_reset(2);
    end else begin
      res = RES_OK;
    end
  endtask

  initial begin
    int res;
    int w;
    logic [3:0] op;

    reset = 1'b1; opcode = 4'd0; acc_zero = 1'b0; acc_neg = 1'b0; mem_ready = 1'b0;
    @(posedge clock);
    #1;
    do_reset(3);

    // Directed cases.
    run_instr(4'd1, 2, 0, 0, -1, res);  after(res);
    run_instr(4'd2, 0, 0, 0, -1, res);  after(res);
    run_instr(4'd9, 0, 1, 0, -1, res);  after(res);
    run_instr(4'd9, 0, 0, 1, -1, res);  after(res);
    run_instr(4'd8, 0, 0, 0, -1, res);  after(res);
    run_instr(4'd10, 0, 1, 1, -1, res); after(res);
    run_instr(4'd10, 0, 1, 0, -1, res); after(res);
    run_instr(4'd7, 0, 0, 0, -1, res);  after(res);
    run_instr(4'd12, 0, 0, 0, -1, res); after(res);
    run_instr(4'd3, WAIT_LIMIT, 0, 0, -1, res); after(res);
    run_instr(4'd2, WAIT_LIMIT, 0, 0, -1, res); after(res);

    // Read timeout, then reset must clear bus_error and halted.
    run_instr(4'd4, 40, 0, 0, -1, res);
    chk_halt(1'b1, 5);
    do_reset(2);
    run_instr(4'd0, 0, 0, 0, -1, res);  after(res);

    // Write timeout.
    run_instr(4'd2, WAIT_LIMIT + 1, 0, 0, -1, res); after(res);

    // HLT holds for 20 cycles despite mem_ready toggling.
    run_instr(4'd15, 0, 0, 0, -1, res);
    chk_halt(1'b0, 20);
    do_reset(2);

    // Reset mid-access.
    run_instr(4'd1, 10, 0, 0, 3, res); after(res);
    run_instr(4'd2, 10, 0, 0, 1, res); after(res);

    // Randomized instruction stream.
    for (int i = 0; i < 300; i++) begin
      op = 4'($urandom_range(0, 15));
      if (op == 4'd15 && $urandom_range(0, 3) != 0) op = 4'd0;
      if ($urandom_range(0, 9) == 0) w = $urandom_range(13, 18);
      else                           w = $urandom_range(0, 3);
      if ($urandom_range(0, 29) == 0)
        run_instr(op, w, 1'($urandom), 1'($urandom), $urandom_range(0, 2), res);
      else
        run_instr(op, w, 1'($urandom), 1'($urandom), -1, res);
      after(res);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/acc_cpu_ctrl.md
Name: acc_cpu_ctrl

Overview:
- Multi-cycle control FSM for the 8-bit accumulator CPU (4-bit PC, 8-bit instruction = opcode[7:4] + operand addr[3:0], 4-bit data address).
- Sequences fetch/decode/memory/execute and drives the datapath strobes ac_src, ld_ac, pc_src and jmp_uncond, plus the memory flags mReadFlag and mWriteFlag.
- Handles variable-latency data memory via a ready handshake with timeout.
- Sits beside the CPU datapath (PC, IR, ACC, ALU) inside the CPU top.

Parameters:
- WAIT_LIMIT, 15: maximum cycles a memory access may wait for mem_ready before a bus error.
- CW, 4: width of the wait counter; must satisfy 2^CW > WAIT_LIMIT.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- opcode  in  4  IR[7:4], valid from DECODE onward.
- acc_zero  in  1  ACC == 0.
- acc_neg  in  1  ACC[7].
- mem_ready  in  1  data memory has completed the current read or write.
- ld_ir  out  1  load IR from the instruction bus.
- ld_pc  out  1  load PC.
- pc_src  out  1  0 = PC+1, 1 = IR operand.
- jmp_uncond  out  1  unconditional jump being taken.
- ld_ac  out  1  load ACC.
- ac_src  out  1  0 = ALU result, 1 = data memory out.
- alu_op  out  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 NOT.
- mReadFlag  out  1  data memory read request.
- mWriteFlag  out  1  data memory write request.
- halted  out  1  controller is in HALT.
- bus_error  out  1  sticky: memory timeout occurred.
- illegal_op  out  1  one-cycle pulse on an undefined opcode.

Behaviour:
- Opcodes:
  - 0 NOP, 1 LDA, 2 STA, 3 ADD, 4 SUB, 5 AND, 6 OR, 7 NOT, 8 JMP, 9 JZ, A JN, F HLT.
  - B–E are illegal.
- State register: FETCH, DECODE, MEM_RD, EXEC, MEM_WR, HALT. Outputs are decoded from state plus inputs.
- Reset:
  - While reset is high, all outputs are 0.
  - At the clock edge with reset high: state <= FETCH, wait counter <= 0, bus_error <= 0.
- FETCH (1 cycle): ld_ir=1, then go to DECODE.
- DECODE (1 cycle):
  - LDA/ADD/SUB/AND/OR: go to MEM_RD.
  - STA: go to MEM_WR.
  - NOT: go to EXEC.
  - NOP: ld_pc=1, pc_src=0, go to FETCH.
  - JMP: ld_pc=1, pc_src=1, jmp_uncond=1, go to FETCH.
  - JZ: ld_pc=1, pc_src=acc_zero, go to FETCH. JN uses acc_neg the same way. jmp_uncond stays 0 for JZ/JN.
  - HLT: go to HALT with no PC update.
  - Illegal: illegal_op=1 and NOP behaviour.
- MEM_RD:
  - mReadFlag=1 every cycle in the state.
  - When mem_ready=1: go to EXEC.
  - Otherwise the counter increments. If the counter equals WAIT_LIMIT with no ready: bus_error<=1, go to HALT.
- EXEC (1 cycle):
  - ld_ac=1, ld_pc=1, pc_src=0, then go to FETCH.
  - LDA: ac_src=1.
  - All others: ac_src=0, with alu_op set per opcode.
  - Data memory out is held by the memory until mReadFlag drops.
- MEM_WR:
  - mWriteFlag=1 every cycle in the state.
  - When mem_ready=1: ld_pc=1, pc_src=0, go to FETCH.
  - Timeout behaves as in MEM_RD.
- Wait counter: cleared on every entry to MEM_RD or MEM_WR. mem_ready in the same cycle the counter hits WAIT_LIMIT wins (no error).
- mReadFlag and mWriteFlag are never high together. ld_ac and mWriteFlag are never high together.
- HALT:
  - All strobes 0, halted=1, state held.
  - Exit only via reset.
  - mem_ready in HALT is ignored.
- Reset asserted mid-access (MEM_RD or MEM_WR) aborts it: flags drop in the same cycle, and there are no ACC or PC loads.
- Latency per instruction, with w = wait cycles before ready:
  - NOP/JMP/JZ/JN: 2 cycles.
  - NOT: 3 cycles.
  - LDA/ALU ops: 4+w cycles.
  - STA: 3+w cycles.
- PC wrap 15→0 is a datapath concern; the controller does not observe it.

Decomposition:
- Shared package acc_cpu_pkg holds:
  - opcode localparams (OP_NOP..OP_HLT);
  - ALU_ADD..ALU_NOT encodings;
  - the state enum encoding;
  - the instruction field positions.
- One natural sub-module: acc_cpu_wait_timer (counter, clear, enable, expired flag), reused by the data path's memory wrapper.
- Decoder and FSM stay inline.

Test Plan:
- Reset held 3 cycles, then release → all outputs 0 during reset; ld_ir=1 in the first cycle after release; DECODE follows.
- opcode=1 (LDA), mem_ready high 2 cycles after MEM_RD entry → mReadFlag high 3 cycles, then a single EXEC cycle with ld_ac=1, ac_src=1, ld_pc=1, pc_src=0; total 6 cycles.
- opcode=2 (STA), mem_ready immediate → mWriteFlag for 1 cycle with ld_pc=1 in that cycle, ld_ac never high, back to FETCH; total 3 cycles.
- opcode=9 with acc_zero=1, then acc_zero=0 → pc_src=1 then pc_src=0, both with ld_pc=1 and jmp_uncond=0; opcode=8 → jmp_uncond=1, pc_src=1.
- opcode=4, mem_ready never asserted → mReadFlag for 16 cycles, then bus_error=1 and halted=1 with all strobes 0; a later reset clears both.
- opcode=C → illegal_op pulses exactly 1 cycle, PC increments; opcode=F → halted=1 persists 20 cycles despite toggling mem_ready.
